// File: rtl/md_pkg.sv
// Shared encodings for the multiply/divide unit: md_op codes and FSM states.
// Op 7 is MADD when MD_MADD_EN is defined, otherwise a reserved no-op.
package md_pkg;

   localparam int MD_OP_W = 3;

   localparam logic [MD_OP_W-1:0] OP_NOP   = 3'd0;
   localparam logic [MD_OP_W-1:0] OP_MULT  = 3'd1;
   localparam logic [MD_OP_W-1:0] OP_MULTU = 3'd2;
   localparam logic [MD_OP_W-1:0] OP_DIV   = 3'd3;
   localparam logic [MD_OP_W-1:0] OP_DIVU  = 3'd4;
   localparam logic [MD_OP_W-1:0] OP_MTHI  = 3'd5;
   localparam logic [MD_OP_W-1:0] OP_MTLO  = 3'd6;
   localparam logic [MD_OP_W-1:0] OP_MADD  = 3'd7;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

endpackage

// File: rtl/md_calc.sv
// Combinational datapath: full 2W-bit mult/div result and a divide-by-zero flag.
// With MD_MADD_EN defined, op 7 accumulates the signed product onto {HI,LO}.
module md_calc
   import md_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [MD_OP_W-1:0]  md_op,
   input  logic [WIDTH-1:0]    inA,
   input  logic [WIDTH-1:0]    inB,
   input  logic [2*WIDTH-1:0]  hilo,
   output logic [2*WIDTH-1:0]  result,
   output logic                div_zero
);

   logic [2*WIDTH-1:0] a_sx, b_sx, a_zx, b_zx;
   logic [2*WIDTH-1:0] prod_s, prod_u;

   assign a_sx   = {{WIDTH{inA[WIDTH-1]}}, inA};
   assign b_sx   = {{WIDTH{inB[WIDTH-1]}}, inB};
   assign a_zx   = {{WIDTH{1'b0}}, inA};
   assign b_zx   = {{WIDTH{1'b0}}, inB};
   // Low 2W bits of the sign-extended product equal the signed product.
   assign prod_s = a_sx * b_sx;
   assign prod_u = a_zx * b_zx;

   // One unsigned divider serves both DIV and DIVU; signed division works on
   // magnitudes and fixes signs afterwards, which also makes MIN/-1 yield MIN.
   logic             is_signed, neg_a, neg_b;
   logic [WIDTH-1:0] dvd, dvs, dvs_safe, q_mag, r_mag, quot, rem;

   assign is_signed = (md_op == OP_DIV);
   assign neg_a     = is_signed & inA[WIDTH-1];
   assign neg_b     = is_signed & inB[WIDTH-1];
   assign dvd       = neg_a ? (~inA + 1'b1) : inA;
   assign dvs       = neg_b ? (~inB + 1'b1) : inB;
   assign dvs_safe  = (dvs == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : dvs;
   assign q_mag     = dvd / dvs_safe;
   assign r_mag     = dvd % dvs_safe;
   assign quot      = (neg_a ^ neg_b) ? (~q_mag + 1'b1) : q_mag;
   assign rem       = neg_a ? (~r_mag + 1'b1) : r_mag;

   always_comb begin
      result   = hilo;
      div_zero = 1'b0;
      case (md_op)
         OP_MULT:  result = prod_s;
         OP_MULTU: result = prod_u;
         OP_DIV, OP_DIVU: begin
            result   = {rem, quot};
            div_zero = (inB == '0);
         end
`ifdef MD_MADD_EN
         OP_MADD:  result = hilo + prod_s;
`endif
         default:  result = hilo;
      endcase
   end

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO; results commit when the busy window ends.
// Optional MD_MADD_EN enables op 7 as a signed multiply-accumulate into {HI,LO}.
module md_unit
   import md_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [MD_OP_W-1:0] md_op,
   input  logic [WIDTH-1:0]   inA,
   input  logic [WIDTH-1:0]   inB,
   output logic               busy,
   output logic [WIDTH-1:0]   HI,
   output logic [WIDTH-1:0]   LO
);

   localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

   logic [0:0]         state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [2*WIDTH-1:0] pend_q, pend_d;
   logic               dz_q, dz_d;
   logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;

   logic [2*WIDTH-1:0] calc_res;
   logic               calc_dz;

   md_calc #(.WIDTH(WIDTH)) u_calc (
      .md_op    (md_op),
      .inA      (inA),
      .inB      (inB),
      .hilo     ({hi_q, lo_q}),
      .result   (calc_res),
      .div_zero (calc_dz)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pend_d  = pend_q;
      dz_d    = dz_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               case (md_op)
                  OP_MULT, OP_MULTU: begin
                     state_d = ST_RUN;
                     cnt_d   = CNT_W'(MULT_CYCLES - 1);
                     pend_d  = calc_res;
                     dz_d    = 1'b0;
                  end
`ifdef MD_MADD_EN
                  OP_MADD: begin
                     state_d = ST_RUN;
                     cnt_d   = CNT_W'(MULT_CYCLES - 1);
                     pend_d  = calc_res;
                     dz_d    = 1'b0;
                  end
`endif
                  OP_DIV, OP_DIVU: begin
                     state_d = ST_RUN;
                     cnt_d   = CNT_W'(DIV_CYCLES - 1);
                     pend_d  = calc_res;
                     dz_d    = calc_dz;
                  end
                  OP_MTHI: hi_d = inA;
                  OP_MTLO: lo_d = inA;
                  default: ;
               endcase
            end
         end
         default: begin
            // Requests arriving here are dropped; the hazard unit stalls them.
            if (cnt_q == '0) begin
               state_d = ST_IDLE;
               if (!dz_q) begin
                  hi_d = pend_q[2*WIDTH-1:WIDTH];
                  lo_d = pend_q[WIDTH-1:0];
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         pend_q  <= '0;
         dz_q    <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
         dz_q    <= dz_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   assign busy = (state_q == ST_RUN);
   assign HI   = hi_q;
   assign LO   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit against a longint-arithmetic reference of HI/LO.
// Build with MD_MADD_EN defined to exercise op 7 as MADD.
module tb_md_unit;

   localparam int MC = 5;
   localparam int DC = 10;

   logic        clk, reset, start, busy;
   logic [2:0]  md_op;
   logic [31:0] inA, inB, HI, LO;

   logic [31:0] m_hi, m_lo;
   int          checks, errors;

   md_unit #(.WIDTH(32), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .md_op (md_op),
      .inA   (inA),
      .inB   (inB),
      .busy  (busy),
      .HI    (HI),
      .LO    (LO)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: updates m_hi/m_lo from the arithmetic rules, returns busy length.
   function automatic int model_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      longint          sa, sb, q, r;
      longint unsigned ua, ub;
      logic [63:0]     p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'd0, a};
      ub = {32'd0, b};
      case (op)
         3'd1: begin p = 64'(sa * sb); m_hi = p[63:32]; m_lo = p[31:0]; return MC; end
         3'd2: begin p = ua * ub;      m_hi = p[63:32]; m_lo = p[31:0]; return MC; end
         3'd3: begin
            if (b != 0) begin q = sa / sb; r = sa % sb; m_lo = q[31:0]; m_hi = r[31:0]; end
            return DC;
         end
         3'd4: begin
            if (b != 0) begin p = ua / ub; m_lo = p[31:0]; p = ua % ub; m_hi = p[31:0]; end
            return DC;
         end
         3'd5: begin m_hi = a; return 0; end
         3'd6: begin m_lo = a; return 0; end
`ifdef MD_MADD_EN
         3'd7: begin p = {m_hi, m_lo} + 64'(sa * sb); m_hi = p[63:32]; m_lo = p[31:0]; return MC; end
`endif
         default: return 0;
      endcase
   endfunction

   // Issues one op and counts the cycles busy is seen high (bounded).
   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, output int cyc);
      @(negedge clk);
      start = 1'b1; md_op = op; inA = a; inB = b;
      @(negedge clk);
      start = 1'b0; md_op = 3'd0;
      cyc = 0;
      while (busy === 1'b1 && cyc < 200) begin
         cyc++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; md_op = 3'd0; inA = '0; inB = '0;
      m_hi = '0; m_lo = '0;
      repeat (3) @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
      checks++; if (HI !== 32'd0) begin errors++; $display("FAIL reset_hi got %h want 00000000", HI); end
      checks++; if (LO !== 32'd0) begin errors++; $display("FAIL reset_lo got %h want 00000000", LO); end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_arith();
      logic [2:0]  ops [6] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd3, 3'd3};
      logic [31:0] as  [6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'd7, 32'h80000000, 32'd100};
      logic [31:0] bs  [6] = '{32'd2, 32'd2, 32'd2, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFF9};
      int exp_cyc, cyc;
      for (int i = 0; i < 6; i++) begin
         exp_cyc = model_op(ops[i], as[i], bs[i]);
         run_op(ops[i], as[i], bs[i], cyc);
         $display("arith op=%0d a=%h b=%h cyc=%0d HI=%h LO=%h", ops[i], as[i], bs[i], cyc, HI, LO);
         checks++; if (cyc !== exp_cyc) begin errors++; $display("FAIL arith_cycles[%0d] got %0d want %0d", i, cyc, exp_cyc); end
         checks++; if ({HI, LO} !== {m_hi, m_lo}) begin errors++;
            $display("FAIL arith_hilo[%0d] got %h_%h want %h_%h", i, HI, LO, m_hi, m_lo); end
      end
   endtask

   task automatic test_div_zero();
      logic [2:0]  ops [4] = '{3'd6, 3'd5, 3'd4, 3'd3};
      logic [31:0] as  [4] = '{32'd0, 32'h12345678, 32'd55, 32'hDEADBEEF};
      int exp_cyc, cyc;
      for (int i = 0; i < 4; i++) begin
         exp_cyc = model_op(ops[i], as[i], 32'd0);
         run_op(ops[i], as[i], 32'd0, cyc);
         $display("divzero op=%0d a=%h cyc=%0d HI=%h LO=%h", ops[i], as[i], cyc, HI, LO);
         checks++; if (cyc !== exp_cyc) begin errors++; $display("FAIL divzero_cycles[%0d] got %0d want %0d", i, cyc, exp_cyc); end
         checks++; if ({HI, LO} !== {m_hi, m_lo}) begin errors++;
            $display("FAIL divzero_hilo[%0d] got %h_%h want %h_%h", i, HI, LO, m_hi, m_lo); end
      end
   endtask

   task automatic test_ignore_busy();
      int exp_cyc, cyc;
      exp_cyc = model_op(3'd1, 32'hFFFFFFFF, 32'd2);
      @(negedge clk);
      start = 1'b1; md_op = 3'd1; inA = 32'hFFFFFFFF; inB = 32'd2;
      @(negedge clk);
      cyc = (busy === 1'b1) ? 1 : 0;
      start = 1'b1; md_op = 3'd3; inA = 32'd9; inB = 32'd4;
      @(negedge clk);
      if (busy === 1'b1) cyc++;
      start = 1'b1; md_op = 3'd6; inA = 32'hAAAAAAAA; inB = 32'd0;
      @(negedge clk);
      start = 1'b0; md_op = 3'd0;
      while (busy === 1'b1 && cyc < 200) begin
         cyc++;
         @(negedge clk);
      end
      $display("ignore mult-with-stray-requests cyc=%0d HI=%h LO=%h", cyc, HI, LO);
      checks++; if (cyc !== exp_cyc) begin errors++; $display("FAIL ignore_cycles got %0d want %0d", cyc, exp_cyc); end
      checks++; if ({HI, LO} !== {m_hi, m_lo}) begin errors++;
         $display("FAIL ignore_hilo got %h_%h want %h_%h", HI, LO, m_hi, m_lo); end
   endtask

   task automatic test_op7();
      int exp_cyc, cyc;
      exp_cyc = model_op(3'd5, 32'd0, 32'd0);          run_op(3'd5, 32'd0, 32'd0, cyc);
      exp_cyc = model_op(3'd6, 32'hFFFFFFFF, 32'd0);   run_op(3'd6, 32'hFFFFFFFF, 32'd0, cyc);
      exp_cyc = model_op(3'd7, 32'd1, 32'd1);
      run_op(3'd7, 32'd1, 32'd1, cyc);
      $display("op7 a=1 b=1 cyc=%0d HI=%h LO=%h", cyc, HI, LO);
      checks++; if (cyc !== exp_cyc) begin errors++; $display("FAIL op7_cycles got %0d want %0d", cyc, exp_cyc); end
      checks++; if ({HI, LO} !== {m_hi, m_lo}) begin errors++;
         $display("FAIL op7_hilo got %h_%h want %h_%h", HI, LO, m_hi, m_lo); end
   endtask

   task automatic test_random();
      logic [2:0]  op;
      logic [31:0] a, b;
      int exp_cyc, cyc;
      for (int i = 0; i < 40; i++) begin
         op = 3'($urandom_range(1, 7));
         a  = $urandom;
         b  = $urandom;
         case ($urandom_range(0, 7))
            0: b = 32'd0;
            1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
            2: b = 32'($urandom_range(1, 15));
            default: ;
         endcase
         exp_cyc = model_op(op, a, b);
         run_op(op, a, b, cyc);
         $display("txn %0d op=%0d a=%h b=%h cyc=%0d HI=%h LO=%h", i, op, a, b, cyc, HI, LO);
         checks++; if (cyc !== exp_cyc) begin errors++; $display("FAIL rand_cycles[%0d] got %0d want %0d", i, cyc, exp_cyc); end
         checks++; if ({HI, LO} !== {m_hi, m_lo}) begin errors++;
            $display("FAIL rand_hilo[%0d] got %h_%h want %h_%h", i, HI, LO, m_hi, m_lo); end
      end
   endtask

   task automatic test_async_abort();
      int exp_cyc, cyc;
      exp_cyc = model_op(3'd5, 32'h0BADF00D, 32'd0);   run_op(3'd5, 32'h0BADF00D, 32'd0, cyc);
      @(negedge clk);
      start = 1'b1; md_op = 3'd3; inA = 32'd1000; inB = 32'd7;
      @(negedge clk);
      start = 1'b0; md_op = 3'd0;
      repeat (3) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      m_hi = '0; m_lo = '0;
      $display("abort div at cycle 4 busy=%b HI=%h LO=%h", busy, HI, LO);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
      checks++; if ({HI, LO} !== {m_hi, m_lo}) begin errors++;
         $display("FAIL abort_hilo got %h_%h want %h_%h", HI, LO, m_hi, m_lo); end
      @(negedge clk);
      reset = 1'b0;
      repeat (DC + 4) @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_late_busy got %b want 0", busy); end
      checks++; if ({HI, LO} !== {m_hi, m_lo}) begin errors++;
         $display("FAIL abort_late_hilo got %h_%h want %h_%h", HI, LO, m_hi, m_lo); end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_arith();
      test_div_zero();
      test_ignore_busy();
      test_op7();
      test_random();
      test_async_abort();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
